// File: rtl/product_display_scanner_pkg.sv
// rtl/product_display_scanner_pkg.sv - shared constants, FSM states and the BCD step for the product display scanner
package display_pkg;

  // Segment patterns {a,b,c,d,e,f,g}, active-high
  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Digit enables on the shared bus
  localparam logic [1:0] AN_OFF  = 2'b00;
  localparam logic [1:0] AN_ONES = 2'b01;
  localparam logic [1:0] AN_TENS = 2'b10;

  // One shift per product bit
  localparam int SHIFT_CYCLES = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // One double-dabble iteration over {tens, ones, binary[5:0]}
  function automatic logic [13:0] dabble_step(input logic [13:0] r);
    logic [13:0] t;
    t = r;
    if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
    if (t[9:6]   >= 4'd5) t[9:6]   = t[9:6]   + 4'd3;
    return {t[12:0], 1'b0};
  endfunction

endpackage

// File: rtl/product_display_scanner_if.sv
// rtl/product_display_scanner_if.sv - product handshake and multiplexed segment bus
interface product_display_scanner_if;
  logic [5:0] product;
  logic       product_valid;
  logic       product_ready;
  logic       done;
  logic [6:0] seg;
  logic [1:0] an;

  modport master (
    output product, product_valid,
    input  product_ready, done, seg, an
  );

  modport slave (
    input  product, product_valid,
    output product_ready, done, seg, an
  );
endinterface

// File: rtl/product_display_scanner_seg7_decoder.sv
// rtl/product_display_scanner_seg7_decoder.sv - combinational BCD digit to 7-segment pattern
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Non-decimal codes fall through to blank
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/product_display_scanner.sv
// rtl/product_display_scanner.sv - binary product to BCD, scanned onto a shared 7-segment bus (option: LEADING_ZERO_BLANK_EN)
module product_display_scanner
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input logic clk,
  input logic rst,
  product_display_scanner_if.slave bus
);

  localparam int CW = $clog2(REFRESH_DIV);

  state_t        state;
  state_t        state_next;
  logic [13:0]   sreg;
  logic [2:0]    iter;
  logic [3:0]    disp_tens;
  logic [3:0]    disp_ones;
  logic          done_r;
  logic [CW-1:0] refresh_cnt;
  logic          digit_sel;
  logic [3:0]    digit_mux;
  logic [6:0]    digit_seg;
  logic [6:0]    seg_next;
  logic [6:0]    seg_r;
  logic [1:0]    an_r;

  assign bus.product_ready = (state == IDLE);
  assign bus.done          = done_r;
  assign bus.seg           = seg_r;
  assign bus.an            = an_r;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: accept in IDLE, six shift cycles, one commit cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.product_valid) state_next = SHIFT;
      SHIFT:   if (iter == 3'(SHIFT_CYCLES - 1)) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Conversion datapath; display registers only move in COMMIT so no partial result is shown
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg      <= '0;
      iter      <= '0;
      disp_tens <= '0;
      disp_ones <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r <= (state == COMMIT);
      case (state)
        IDLE: begin
          if (bus.product_valid) begin
            sreg <= {8'b0, bus.product};
            iter <= '0;
          end
        end
        SHIFT: begin
          sreg <= dabble_step(sreg);
          iter <= iter + 3'd1;
        end
        COMMIT: begin
          disp_tens <= sreg[13:10];
          disp_ones <= sreg[9:6];
        end
        default: ;
      endcase
    end
  end

  // Refresh counter; digit_sel flips each time the counter wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_sel   <= 1'b0;
    end else if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      digit_sel   <= ~digit_sel;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Single decoder shared by both digits through the select mux
  always_comb begin
    digit_mux = digit_sel ? disp_tens : disp_ones;
  end

  seg7_decoder u_dec (
    .digit (digit_mux),
    .seg   (digit_seg)
  );

  // Optional suppression of a leading zero on the tens digit
  always_comb begin
    seg_next = digit_seg;
`ifdef LEADING_ZERO_BLANK_EN
    if (digit_sel && (disp_tens == 4'd0)) seg_next = SEG_BLANK;
`endif
  end

  // Registered bus outputs; an and seg always move together
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r <= SEG_BLANK;
      an_r  <= AN_OFF;
    end else begin
      seg_r <= seg_next;
      an_r  <= digit_sel ? AN_TENS : AN_ONES;
    end
  end

endmodule
